// File: rtl/sweep_ctrl_pkg.sv
// Shared types and defaults for the tx/rx sweep sequencer.
package sweep_ctrl_pkg;

  localparam int unsigned SWEEP_TX_W       = 4;
  localparam int unsigned SWEEP_RX_W       = 4;
  localparam int unsigned SWEEP_ERR_W      = 32;
  localparam int unsigned SWEEP_TO_W       = 32;
  localparam int unsigned SWEEP_RST_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_REPORT,
    ST_NEXT,
    ST_DONE
  } sweep_state_e;

endpackage

// File: rtl/sweep_ctrl_grid.sv
// Nested tx/rx setting counters, rx innermost; saturates at the last grid point.
module sweep_ctrl_grid #(
  parameter int unsigned TX_W = 4,
  parameter int unsigned RX_W = 4
) (
  input  logic            clk_sys,
  input  logic            rst,
  input  logic            clear,
  input  logic            inc,
  input  logic [TX_W-1:0] tx_max,
  input  logic [RX_W-1:0] rx_max,
  output logic [TX_W-1:0] tx,
  output logic [RX_W-1:0] rx,
  output logic            last_c
);

  assign last_c = (tx == tx_max) && (rx == rx_max);

  always_ff @(posedge clk_sys) begin
    if (rst || clear) begin
      tx <= '0;
      rx <= '0;
    end else if (inc && !last_c) begin
      if (rx < rx_max) begin
        rx <= rx + RX_W'(1);
      end else begin
        rx <= '0;
        if (tx < tx_max) tx <= tx + TX_W'(1);
      end
    end
  end

endmodule

// File: rtl/sweep_ctrl.sv
// Run sequencer: walks the tx/rx grid, pulses DUT reset per point and
// hands one result record per point to the host over valid/ready.
module sweep_ctrl
  import sweep_ctrl_pkg::*;
#(
  parameter int unsigned TX_W       = SWEEP_TX_W,
  parameter int unsigned RX_W       = SWEEP_RX_W,
  parameter int unsigned ERR_W      = SWEEP_ERR_W,
  parameter int unsigned RST_CYCLES = SWEEP_RST_CYCLES,
  parameter int unsigned TO_W       = SWEEP_TO_W
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [TX_W-1:0]  tx_max,
  input  logic [RX_W-1:0]  rx_max,
  input  logic [TO_W-1:0]  timeout_cycles,
  output logic             dut_rst,
  output logic [TX_W-1:0]  tx_setting,
  output logic [RX_W-1:0]  rx_setting,
  input  logic             sim_done,
  input  logic [ERR_W-1:0] err_count,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TX_W-1:0]  res_tx,
  output logic [RX_W-1:0]  res_rx,
  output logic [ERR_W-1:0] res_err,
  output logic             res_timeout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned RC_W = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;

  typedef struct packed {
    logic [TX_W-1:0]  tx;
    logic [RX_W-1:0]  rx;
    logic [ERR_W-1:0] err;
    logic             timeout;
  } result_t;

  sweep_state_e    state, state_next;
  logic [RC_W-1:0] rst_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_l;
  logic [TX_W-1:0] tx_max_l;
  logic [RX_W-1:0] rx_max_l;
  result_t         res_q;

  logic grid_clear_c;
  logic grid_inc_c;
  logic grid_last_c;
  logic timeout_hit_c;
  logic capture_c;

  sweep_ctrl_grid #(
    .TX_W (TX_W),
    .RX_W (RX_W)
  ) u_grid (
    .clk_sys (clk_sys),
    .rst     (rst),
    .clear   (grid_clear_c),
    .inc     (grid_inc_c),
    .tx_max  (tx_max_l),
    .rx_max  (rx_max_l),
    .tx      (tx_setting),
    .rx      (rx_setting),
    .last_c  (grid_last_c)
  );

  assign timeout_hit_c = (to_l != '0) && (to_cnt == to_l - TO_W'(1));
  assign capture_c     = (state == ST_RUN) && (state_next == ST_REPORT);

  assign res_tx      = res_q.tx;
  assign res_rx      = res_q.rx;
  assign res_err     = res_q.err;
  assign res_timeout = res_q.timeout;

  always_ff @(posedge clk_sys) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Abort outranks everything; sim_done outranks timeout in RUN.
  always_comb begin
    state_next   = state;
    grid_clear_c = 1'b0;
    grid_inc_c   = 1'b0;
    if (abort && (state != ST_IDLE)) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            grid_clear_c = 1'b1;
            state_next   = ST_RESET;
          end
        end
        ST_RESET: begin
          if (rst_cnt == '0) state_next = ST_RUN;
        end
        ST_RUN: begin
          if (sim_done || timeout_hit_c) state_next = ST_REPORT;
        end
        ST_REPORT: begin
          if (res_ready) state_next = ST_NEXT;
        end
        ST_NEXT: begin
          if (grid_last_c) begin
            state_next = ST_DONE;
          end else begin
            grid_inc_c = 1'b1;
            state_next = ST_RESET;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Counters, latched sweep limits, result capture and registered outputs.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      rst_cnt   <= RC_W'(RST_CYCLES - 1);
      to_cnt    <= '0;
      to_l      <= '0;
      tx_max_l  <= '0;
      rx_max_l  <= '0;
      res_q     <= '0;
      dut_rst   <= 1'b1;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rst_cnt <= (state == ST_RESET) ? rst_cnt - RC_W'(1) : RC_W'(RST_CYCLES - 1);
      to_cnt  <= (state == ST_RUN) ? to_cnt + TO_W'(1) : '0;
      if (grid_clear_c) begin
        tx_max_l <= tx_max;
        rx_max_l <= rx_max;
        to_l     <= timeout_cycles;
      end
      if (capture_c) begin
        res_q.tx      <= tx_setting;
        res_q.rx      <= rx_setting;
        res_q.err     <= err_count;
        res_q.timeout <= !sim_done;
      end
      dut_rst   <= (state_next != ST_RUN);
      res_valid <= (state_next == ST_REPORT);
      busy      <= (state_next == ST_RESET) || (state_next == ST_RUN) ||
                   (state_next == ST_REPORT) || (state_next == ST_NEXT);
      done      <= (state_next == ST_DONE);
    end
  end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl with a small emulator-DUT model.
module tb_sweep_ctrl;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [3:0]  tx_max;
  logic [3:0]  rx_max;
  logic [31:0] timeout_cycles;
  logic        dut_rst;
  logic [3:0]  tx_setting;
  logic [3:0]  rx_setting;
  logic        sim_done;
  logic [31:0] err_count;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_tx;
  logic [3:0]  res_rx;
  logic [31:0] res_err;
  logic        res_timeout;
  logic        busy;
  logic        done;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk_sys = ~clk_sys;

  sweep_ctrl dut (
    .clk_sys        (clk_sys),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .tx_max         (tx_max),
    .rx_max         (rx_max),
    .timeout_cycles (timeout_cycles),
    .dut_rst        (dut_rst),
    .tx_setting     (tx_setting),
    .rx_setting     (rx_setting),
    .sim_done       (sim_done),
    .err_count      (err_count),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_tx         (res_tx),
    .res_rx         (res_rx),
    .res_err        (res_err),
    .res_timeout    (res_timeout),
    .busy           (busy),
    .done           (done)
  );

  // Emulator model: cyc counts cycles since dut_rst fell, done after done_after.
  logic sim_en;
  int   done_after;
  int   cyc = 0;
  always @(posedge clk_sys) begin
    if (dut_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end
  assign sim_done  = sim_en && !dut_rst && (cyc >= done_after);
  assign err_count = 32'(tx_setting) * 32'd10 + 32'(rx_setting);

  // Length of the most recent dut_rst-low window, in clk_sys cycles.
  int low_cur  = 0;
  int low_last = 0;
  always @(posedge clk_sys) begin
    if (!dut_rst) begin
      low_cur <= low_cur + 1;
    end else begin
      if (low_cur != 0) low_last <= low_cur;
      low_cur <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
  endtask

  task automatic get_result(input int etx, input int erx, input int eerr,
                            input int eto, input int stall);
    int n;
    n = 0;
    while (!res_valid && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    if (!res_valid) begin
      check("res_valid_wait", 32'(res_valid), 32'd1);
      return;
    end
    check("res_tx", 32'(res_tx), 32'(etx));
    check("res_rx", 32'(res_rx), 32'(erx));
    check("res_err", res_err, 32'(eerr));
    check("res_timeout", 32'(res_timeout), 32'(eto));
    check("report_dut_rst", 32'(dut_rst), 32'd1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_sys);
      check("stall_hold", {24'd0, res_valid, dut_rst, res_timeout, res_tx[0], res_rx},
            {24'd0, 1'b1, 1'b1, 1'(eto), 1'(etx), 4'(erx)});
      check("stall_err", res_err, 32'(eerr));
    end
    res_ready = 1'b1;
    @(negedge clk_sys);
    check("valid_drop", 32'(res_valid), 32'd0);
    if (stall > 0) res_ready = 1'b0;
  endtask

  task automatic check_done(input int etx, input int erx);
    @(negedge clk_sys);
    check("done", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_dut_rst", 32'(dut_rst), 32'd1);
    check("done_settings", {24'd0, tx_setting, rx_setting}, 32'({4'(etx), 4'(erx)}));
  endtask

  initial begin
    int n;
    int bad;
    rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
    tx_max = 4'd1; rx_max = 4'd2; timeout_cycles = 32'd0;
    sim_en = 1'b1; done_after = 100;

    repeat (3) @(negedge clk_sys);
    check("rst_dut_rst", 32'(dut_rst), 32'd1);
    check("rst_settings", {24'd0, tx_setting, rx_setting}, 32'd0);
    check("rst_res", {res_valid, res_timeout, res_tx, res_rx, 22'd0}, 32'd0);
    check("rst_res_err", res_err, 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk_sys);
    check("idle_busy", 32'(busy), 32'd0);

    // 1: 2x3 grid, host always ready
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_settings", {24'd0, tx_setting, rx_setting}, 32'd0);
    for (int t = 0; t <= 1; t++)
      for (int r = 0; r <= 2; r++)
        get_result(t, r, t * 10 + r, 0, 0);
    check_done(1, 2);

    // 2: same grid with host stalls; max inputs changed mid-sweep
    res_ready = 1'b0;
    pulse_start();
    tx_max = 4'd0; rx_max = 4'd0;
    for (int t = 0; t <= 1; t++)
      for (int r = 0; r <= 2; r++)
        get_result(t, r, t * 10 + r, 0, 20);
    res_ready = 1'b1;
    check_done(1, 2);

    // 3: timeout only
    tx_max = 4'd0; rx_max = 4'd1; timeout_cycles = 32'd50; sim_en = 1'b0;
    pulse_start();
    for (int r = 0; r <= 1; r++) begin
      get_result(0, r, r, 1, 0);
      check("timeout_low_len", 32'(low_last), 32'd50);
    end
    check_done(0, 1);

    // 4: sim_done on the timeout terminal count
    tx_max = 4'd0; rx_max = 4'd0; sim_en = 1'b1; done_after = 49;
    pulse_start();
    get_result(0, 0, 0, 0, 0);
    check("tie_low_len", 32'(low_last), 32'd50);
    check_done(0, 0);

    // 5: abort during RUN of point (0,1), then restart
    tx_max = 4'd1; rx_max = 4'd2; timeout_cycles = 32'd0; done_after = 100;
    pulse_start();
    get_result(0, 0, 0, 0, 0);
    n = 0;
    while (dut_rst && n < 500) begin
      @(negedge clk_sys);
      n++;
    end
    check("abort_run_entered", 32'(dut_rst), 32'd0);
    check("abort_point", {24'd0, tx_setting, rx_setting}, 32'h01);
    repeat (30) @(negedge clk_sys);
    abort = 1'b1;
    @(negedge clk_sys);
    abort = 1'b0;
    check("abort_state", {28'd0, dut_rst, res_valid, busy, done}, 32'b1000);
    bad = 0;
    repeat (200) begin
      @(negedge clk_sys);
      if (res_valid || !dut_rst || busy) bad++;
    end
    check("abort_quiet", 32'(bad), 32'd0);
    pulse_start();
    check("restart_settings", {24'd0, tx_setting, rx_setting}, 32'd0);
    for (int t = 0; t <= 1; t++)
      for (int r = 0; r <= 2; r++)
        get_result(t, r, t * 10 + r, 0, 0);
    check_done(1, 2);

    // 6: single point; start while busy is ignored
    tx_max = 4'd0; rx_max = 4'd0; done_after = 20;
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    check("single_busy", 32'(busy), 32'd1);
    n = 0;
    while (dut_rst && n < 100) begin
      n++;
      @(negedge clk_sys);
    end
    check("reset_pulse_len", 32'(n), 32'd16);
    pulse_start();
    get_result(0, 0, 0, 0, 0);
    check_done(0, 0);
    bad = 0;
    repeat (150) begin
      @(negedge clk_sys);
      if (res_valid || busy || !done) bad++;
    end
    check("single_no_extra", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected end before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sweep_ctrl.md
Name: sweep_ctrl

Overview:
Run sequencer for the link emulator DUT. It steps tx_setting and rx_setting through a rectangular grid and pulses the DUT reset for each grid point. It waits for sim_done or a timeout, latches the DUT's error count, and hands one result record per grid point to the host through a valid/ready interface. It sits above the emulator top level, in the clk_sys domain, and replaces the static setting pins driven by the host.

Parameters:
TX_W, 4, width of tx_setting (match TX_SETTING_WIDTH)
RX_W, 4, width of rx_setting (match RX_SETTING_WIDTH)
ERR_W, 32, width of DUT error count
RST_CYCLES, 16, DUT reset pulse length in clk_sys cycles; must be >= 2
TO_W, 32, width of timeout counter

Ports:
clk_sys  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  begin sweep; level-sampled in IDLE/DONE only
abort  in  1  cancel sweep; return to IDLE
tx_max  in  TX_W  last tx setting (inclusive)
rx_max  in  RX_W  last rx setting (inclusive)
timeout_cycles  in  TO_W  RUN-state limit; 0 disables timeout
dut_rst  out  1  reset to DUT
tx_setting  out  TX_W  to DUT
rx_setting  out  RX_W  to DUT
sim_done  in  1  DUT run complete
err_count  in  ERR_W  DUT error count, stable while sim_done=1
res_valid  out  1  result available
res_ready  in  1  host accepts result
res_tx  out  TX_W  tx setting of result
res_rx  out  RX_W  rx setting of result
res_err  out  ERR_W  captured error count
res_timeout  out  1  run ended by timeout
busy  out  1  sweep in progress
done  out  1  sweep complete (sticky)

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk_sys.
- Reset values:
  - dut_rst=1; tx_setting=0, rx_setting=0.
  - res_valid=0, res_*=0.
  - busy=0, done=0; state=IDLE.
- States: IDLE, RESET, RUN, REPORT, NEXT, DONE.
- IDLE:
  - dut_rst=1.
  - start=1 → latch tx_max/rx_max/timeout_cycles into internal regs; tx_setting=0, rx_setting=0, done=0; → RESET.
- RESET:
  - dut_rst=1 for exactly RST_CYCLES cycles (down-counter); → RUN.
  - Settings are stable for the whole pulse.
- RUN:
  - dut_rst=0; timeout counter increments from 0 each cycle.
  - sim_done=1 → capture err_count into res_err, res_timeout=0; → REPORT.
  - Otherwise, if timeout_cycles≠0 and counter==timeout_cycles-1 → res_err=err_count, res_timeout=1; → REPORT.
  - sim_done and timeout in the same cycle: sim_done wins, res_timeout=0.
- REPORT:
  - dut_rst=1 to freeze the DUT.
  - res_valid=1; res_tx/res_rx = current settings.
  - Hold all res_* stable until res_valid&&res_ready; → NEXT. res_valid drops the following cycle.
- NEXT (1 cycle), row-major, rx innermost:
  - rx<rx_max_l → rx+1 → RESET.
  - else rx=0; tx<tx_max_l → tx+1 → RESET.
  - else → DONE.
- DONE:
  - done=1, busy=0, dut_rst=1; settings hold their last values.
  - start=1 → same action as in IDLE.
- busy=1 in RESET, RUN, REPORT, NEXT.
- abort=1 in any state except IDLE: → IDLE next cycle. dut_rst=1, res_valid=0, done=0, no partial result. abort has priority over every other transition.
- start while busy is ignored.
- Changes on tx_max/rx_max during a sweep have no effect; the latched copies are used.
- Grid point count is (tx_max+1)*(rx_max+1); tx_max=rx_max=0 gives a single run.
- No wrap-around on settings: counters never exceed the latched max.

Decomposition:
- Package sweep_package: state enum typedef SWEEP_STATE; result struct typedef SWEEP_RESULT {tx, rx, err, timeout}; default constant SWEEP_RST_CYCLES.
- Widths come from tx_package/filter_package setting-width constants.
- One natural sub-module: sweep_grid_cnt. It holds the two nested setting counters, with inputs inc/clear/max and outputs values plus a last flag.

Test Plan:
1. tx_max=1, rx_max=2, timeout=0, DUT model asserts sim_done 100 cycles after dut_rst falls with err_count=tx*10+rx, res_ready=1 → 6 results in order (0,0)…(1,2), res_err=0,1,2,10,11,12, then done=1, busy=0.
2. Same sweep with res_ready low for 20 cycles on each result → res_valid/res_* stable throughout, no run starts while stalled, the order of scenario 1 is preserved.
3. timeout=50, sim_done never asserted → each result has res_timeout=1, with dut_rst low for exactly 50 cycles per point.
4. sim_done and timeout terminal count in the same cycle → res_timeout=0, err captured.
5. abort at cycle 30 of RUN for point (0,1) → IDLE next cycle, dut_rst=1, no res_valid. A following start restarts at (0,0).
6. tx_max=rx_max=0 → one RESET pulse of exactly RST_CYCLES cycles, one result, done=1. start pulsed while busy produces no extra run.
